// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Purpose  : Shared types, frame constants, field slices and checksum helper
//            for the DHT11 poll scheduler.
// Revision : 1.0  initial release
// ============================================================================
package dht11_pkg;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_RSP  = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FAIL      = 3'd4,
        ST_GAP       = 3'd5,
        ST_SEND      = 3'd6,
        ST_IDLE      = 3'd7
    } state_t;

    // Frame constants
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    // Field positions inside the 40-bit reader word
    localparam int HUM_H_HI = 39;
    localparam int HUM_H_LO = 32;
    localparam int HUM_L_HI = 31;
    localparam int HUM_L_LO = 24;
    localparam int TMP_H_HI = 23;
    localparam int TMP_H_LO = 16;
    localparam int TMP_L_HI = 15;
    localparam int TMP_L_LO = 8;
    localparam int CHK_HI   = 7;
    localparam int CHK_LO   = 0;

    // Sum of the four data bytes modulo 256 must equal the checksum byte
    function automatic logic checksum_ok(input logic [39:0] word);
        logic [7:0] sum;
        sum = word[HUM_H_HI:HUM_H_LO] + word[HUM_L_HI:HUM_L_LO]
            + word[TMP_H_HI:TMP_H_LO] + word[TMP_L_HI:TMP_L_LO];
        return (sum == word[CHK_HI:CHK_LO]);
    endfunction

    // Larger of two integers, used to size the shared cycle counter
    function automatic int cnt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_frame_ser.sv
`default_nettype none
// ============================================================================
// Module   : dht11_frame_ser
// Purpose  : Serialises one good DHT11 sample into the UART tx byte stream
//            with a valid/ready handshake.
//            DHT11_POLL_SCHED_ASCII_EN defined : 10-byte ASCII hex frame + CR LF
//            DHT11_POLL_SCHED_ASCII_EN undefined: raw 6-byte frame, header A5
// Revision : 1.0  initial release
// ============================================================================
module dht11_frame_ser
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] sample,
    input  logic [7:0]  chk,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

`ifdef DHT11_POLL_SCHED_ASCII_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd5;
`endif

    logic [31:0] sample_q;
    logic [3:0]  idx;
    logic        busy;
    logic        accept;
    logic [7:0]  byte_sel;

    assign accept   = busy && tx_ready;
    assign done     = accept && (idx == LAST_IDX);
    assign tx_valid = busy;
    // Data is forced to zero when idle so the port reads 0 out of reset
    assign tx_data  = busy ? byte_sel : 8'h00;

    // Frame capture and byte index; the next byte appears the cycle after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 32'h0;
            idx      <= 4'd0;
            busy     <= 1'b0;
        end else if (load) begin
            sample_q <= sample;
            idx      <= 4'd0;
            busy     <= 1'b1;
        end else if (accept) begin
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
            end else begin
                idx <= idx + 4'd1;
            end
        end
    end

`ifdef DHT11_POLL_SCHED_ASCII_EN
    logic [5:0] shift;
    logic [3:0] nib;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Eight hex digits MSB first, then CR LF
    always_comb begin
        shift    = 6'd28 - {idx, 2'b00};
        nib      = 4'(sample_q >> shift);
        byte_sel = hex_ascii(nib);
        if (idx == 4'd8) begin
            byte_sel = ASCII_CR;
        end else if (idx == 4'd9) begin
            byte_sel = ASCII_LF;
        end
    end
`else
    logic [7:0] chk_q;

    // Checksum byte is only carried in the raw frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else if (load) begin
            chk_q <= chk;
        end
    end

    // Header, four data bytes, checksum
    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            4'd0:    byte_sel = FRAME_HDR;
            4'd1:    byte_sel = sample_q[31:24];
            4'd2:    byte_sel = sample_q[23:16];
            4'd3:    byte_sel = sample_q[15:8];
            4'd4:    byte_sel = sample_q[7:0];
            4'd5:    byte_sel = chk_q;
            default: byte_sel = 8'h00;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/dht11_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : dht11_poll_sched
// Purpose  : Periodic read scheduler between the DHT11 reader and UART tx.
//            Waits out power-up, starts a read every POLL_CNT cycles,
//            validates/retries results and streams good samples out.
//            Build option DHT11_POLL_SCHED_ASCII_EN selects the ASCII frame.
// Revision : 1.0  initial release
// ============================================================================
module dht11_poll_sched
    import dht11_pkg::*;
#(
    parameter int INIT_DELAY_CNT = 25_000_000,
    parameter int POLL_CNT       = 50_000_000,
    parameter int TIMEOUT_CNT    = 250_000,
    parameter int RETRY_GAP_CNT  = 25_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_dht_start,
    input  logic        i_dht_done,
    input  logic        i_dht_err,
    input  logic [39:0] i_dht_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_sample,
    output logic        o_sample_vld,
    output logic [7:0]  o_err_cnt
);

    localparam int CNT_MAX = cnt_max(cnt_max(INIT_DELAY_CNT, POLL_CNT),
                                     cnt_max(TIMEOUT_CNT, RETRY_GAP_CNT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY_CNT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RETRY_GAP_CNT - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CNT - 1);
    localparam logic [CNT_W-1:0] POLL_SAT  = CNT_W'(POLL_CNT);
    localparam logic [3:0]       RETRY_TOP = 4'(MAX_RETRY - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [39:0]      rsp_data;
    logic [3:0]       retry_cnt;
    logic             chk_good;
    logic             retry_last;
    logic             ser_load;
    logic             ser_done;

    assign chk_good   = checksum_ok(rsp_data);
    assign retry_last = (retry_cnt >= RETRY_TOP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and decoded outputs
    always_comb begin
        state_next  = state;
        o_dht_start = 1'b0;
        ser_load    = 1'b0;
        case (state)
            ST_INIT_WAIT: begin
                if (wait_cnt == INIT_LAST) state_next = ST_START;
            end
            ST_START: begin
                o_dht_start = 1'b1;
                state_next  = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                // done wins over a simultaneous error
                if (i_dht_done) begin
                    state_next = ST_CHECK;
                end else if (i_dht_err || (wait_cnt >= TMO_LAST)) begin
                    state_next = ST_FAIL;
                end
            end
            ST_CHECK: begin
                ser_load   = chk_good;
                state_next = chk_good ? ST_SEND : ST_FAIL;
            end
            ST_FAIL: begin
                state_next = retry_last ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (wait_cnt == GAP_LAST) state_next = ST_START;
            end
            ST_SEND: begin
                if (ser_done) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (period_cnt >= POLL_LAST) state_next = ST_START;
            end
            default: state_next = ST_INIT_WAIT;
        endcase
    end

    // Per-state cycle counter; carries through START so the timeout is measured from the start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_next != state) && (state != ST_START)) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Cycles since the last start pulse, saturating once the poll period has elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (state == ST_START) begin
            period_cnt <= CNT_W'(1);
        end else if (period_cnt < POLL_SAT) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Capture reader word; pulses outside WAIT_RSP are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= 40'h0;
        end else if ((state == ST_WAIT_RSP) && i_dht_done) begin
            rsp_data <= i_dht_data;
        end
    end

    // Publish a validated sample with a one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sample     <= 32'h0;
            o_sample_vld <= 1'b0;
        end else begin
            o_sample_vld <= (state == ST_CHECK) && chk_good;
            if ((state == ST_CHECK) && chk_good) begin
                o_sample <= rsp_data[39:8];
            end
        end
    end

    // Retry bookkeeping and saturating count of abandoned polls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= 4'd0;
            o_err_cnt <= 8'h00;
        end else if ((state == ST_CHECK) && chk_good) begin
            retry_cnt <= 4'd0;
        end else if (state == ST_FAIL) begin
            if (retry_last) begin
                retry_cnt <= 4'd0;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'h01;
            end else begin
                retry_cnt <= retry_cnt + 4'd1;
            end
        end
    end

    dht11_frame_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .sample   (rsp_data[39:8]),
        .chk      (rsp_data[7:0]),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .tx_ready (i_tx_ready),
        .done     (ser_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_dht11_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_poll_sched
// Purpose  : Self-checking scoreboard bench for dht11_poll_sched.
//            Honors DHT11_POLL_SCHED_ASCII_EN for the expected frame format.
// Revision : 1.0  initial release
// ============================================================================
module tb_dht11_poll_sched;

    localparam int P_INIT  = 100;
    localparam int P_POLL  = 5000;
    localparam int P_TMO   = 500;
    localparam int P_GAP   = 200;
    localparam int P_RETRY = 3;

    localparam logic [39:0] GOOD_A = 40'h35_00_18_2A_77;
    localparam logic [39:0] BAD_A  = 40'h35_00_18_2A_78;
    localparam logic [39:0] GOOD_B = 40'hFF_FF_02_03_03;  // checksum wraps mod 256
    localparam logic [39:0] GOOD_C = 40'h2A_00_19_05_48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_dht_start;
    logic        i_dht_done = 1'b0;
    logic        i_dht_err  = 1'b0;
    logic [39:0] i_dht_data = 40'h0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_sample;
    logic        o_sample_vld;
    logic [7:0]  o_err_cnt;

    dht11_poll_sched #(
        .INIT_DELAY_CNT (P_INIT),
        .POLL_CNT       (P_POLL),
        .TIMEOUT_CNT    (P_TMO),
        .RETRY_GAP_CNT  (P_GAP),
        .MAX_RETRY      (P_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .o_dht_start  (o_dht_start),
        .i_dht_done   (i_dht_done),
        .i_dht_err    (i_dht_err),
        .i_dht_data   (i_dht_data),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_sample     (o_sample),
        .o_sample_vld (o_sample_vld),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Cycles since reset release
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard queues
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_samp[$];

    function automatic logic sum_ok(input logic [39:0] d);
        logic [7:0] s;
        s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        return s == d[7:0];
    endfunction

    task automatic push_frame(input logic [39:0] d);
`ifdef DHT11_POLL_SCHED_ASCII_EN
        for (int i = 0; i < 8; i++) begin
            logic [3:0] n;
            n = 4'(d >> (36 - 4 * i));
            exp_bytes.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
        end
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
`else
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(d[39:32]);
        exp_bytes.push_back(d[31:24]);
        exp_bytes.push_back(d[23:16]);
        exp_bytes.push_back(d[15:8]);
        exp_bytes.push_back(d[7:0]);
`endif
        exp_samp.push_back(d[39:8]);
    endtask

    // tx_ready driver: stall_len low cycles before accepting each byte
    int stall_len = 0;
    int stall_ctr = 0;
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_len == 0 || rst) begin
                i_tx_ready = 1'b1;
                stall_ctr  = 0;
            end else if (o_tx_valid) begin
                if (stall_ctr >= stall_len) begin
                    i_tx_ready = 1'b1;
                    stall_ctr  = 0;
                end else begin
                    i_tx_ready = 1'b0;
                    stall_ctr++;
                end
            end else begin
                i_tx_ready = 1'b0;
                stall_ctr  = 0;
            end
        end
    end

    // Output monitor: pops the scoreboard and checks stall stability
    logic       last_stall = 1'b0;
    logic [7:0] last_data  = 8'h0;
    int         acc_cnt    = 0;
    int         last_acc_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            last_stall = 1'b0;
            acc_cnt    = 0;
        end else begin
            if (last_stall) begin
                check_val("stall_valid_held", 64'(o_tx_valid), 64'd1);
                check_val("stall_data_held", 64'(o_tx_data), 64'(last_data));
            end
            if (o_tx_valid && i_tx_ready) begin
                check_val("tx_byte_expected", 64'(exp_bytes.size() > 0), 64'd1);
                if (exp_bytes.size() > 0) check_val("tx_byte", 64'(o_tx_data), 64'(exp_bytes.pop_front()));
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            last_stall = o_tx_valid && !i_tx_ready;
            last_data  = o_tx_data;
            if (o_sample_vld) begin
                check_val("sample_expected", 64'(exp_samp.size() > 0), 64'd1);
                if (exp_samp.size() > 0) check_val("sample_value", 64'(o_sample), 64'(exp_samp.pop_front()));
            end
        end
    end

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_dht_start) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic reply(input int dly, input logic [39:0] d, input bit dn, input bit er, input bit accept);
        repeat (dly) @(negedge clk);
        i_dht_data = d;
        i_dht_done = dn;
        i_dht_err  = er;
        if (accept && dn && sum_ok(d)) push_frame(d);
        @(negedge clk);
        i_dht_done = 1'b0;
        i_dht_err  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || o_tx_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst        = 1'b1;
        i_dht_done = 1'b0;
        i_dht_err  = 1'b0;
        stall_len  = 0;
        repeat (3) @(posedge clk);
        #3;
        exp_bytes.delete();
        exp_samp.delete();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    int t;
    int s;
    int n;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check_val("rst_dht_start", 64'(o_dht_start), 64'd0);
        check_val("rst_tx_valid", 64'(o_tx_valid), 64'd0);
        check_val("rst_tx_data", 64'(o_tx_data), 64'd0);
        check_val("rst_sample", 64'(o_sample), 64'd0);
        check_val("rst_sample_vld", 64'(o_sample_vld), 64'd0);
        check_val("rst_err_cnt", 64'(o_err_cnt), 64'd0);
        rst = 1'b0;

        // Good read, frame, stray pulse in IDLE ignored, next poll
        wait_start(P_INIT + 50, t);
        check_val("t1_first_start", 64'(t), 64'(P_INIT));
        s = t;
        reply(50, GOOD_A, 1'b1, 1'b0, 1'b1);
        wait_drain("t1_drain", 300);
        check_val("t1_sample", 64'(o_sample), 64'h3500182A);
        reply(5, GOOD_C, 1'b1, 1'b0, 1'b0);
        wait_start(P_POLL, t);
        check_val("t1_poll_start", 64'(t), 64'(s + P_POLL));
        check_val("t1_err_cnt", 64'(o_err_cnt), 64'd0);

        // Bad checksum on every attempt
        apply_reset();
        wait_start(P_INIT + 50, t);
        check_val("t2_first_start", 64'(t), 64'(P_INIT));
        s = t;
        for (int a = 0; a < P_RETRY; a++) begin
            if (a > 0) begin
                wait_start(P_GAP + 100, t);
                check_val("t2_retry_start", 64'(t), 64'(s + 50 + 3 + P_GAP));
                s = t;
            end
            reply(50, BAD_A, 1'b1, 1'b0, 1'b1);
        end
        wait_start(P_POLL + 10, t);
        check_val("t2_poll_after_abandon", 64'(t), 64'(s + P_POLL));
        check_val("t2_err_cnt", 64'(o_err_cnt), 64'd1);
        check_val("t2_no_bytes", 64'(acc_cnt), 64'd0);

        // Timeout then good retry (wrapping checksum)
        apply_reset();
        wait_start(P_INIT + 50, t);
        s = t;
        wait_start(P_TMO + P_GAP + 50, t);
        check_val("t3_timeout_retry", 64'(t), 64'(s + P_TMO + 1 + P_GAP));
        reply(50, GOOD_B, 1'b1, 1'b0, 1'b1);
        wait_drain("t3_drain", 300);
        check_val("t3_sample", 64'(o_sample), 64'hFFFF0203);
        check_val("t3_err_cnt", 64'(o_err_cnt), 64'd0);

        // Reader error, then done and err together (done wins)
        apply_reset();
        wait_start(P_INIT + 50, t);
        s = t;
        reply(10, GOOD_C, 1'b0, 1'b1, 1'b0);
        wait_start(P_GAP + 100, t);
        check_val("t3b_err_retry", 64'(t), 64'(s + 10 + 2 + P_GAP));
        reply(30, GOOD_C, 1'b1, 1'b1, 1'b1);
        wait_drain("t3b_drain", 300);
        check_val("t3b_sample", 64'(o_sample), 64'h2A001905);

        // Long tx stalls push the frame past the poll period
        apply_reset();
        stall_len = 900;
        wait_start(P_INIT + 50, t);
        s = t;
        reply(50, GOOD_A, 1'b1, 1'b0, 1'b1);
        wait_start(P_POLL + 7 * 950, t);
        check_val("t4_frame_complete", 64'(exp_bytes.size()), 64'd0);
        check_val("t4_start_after_last", 64'(t), 64'(last_acc_cyc + 2));
        check_val("t4_start_late", 64'(t > s + P_POLL), 64'd1);
        stall_len = 0;

        // Reset in the middle of the frame
        apply_reset();
        stall_len = 20;
        wait_start(P_INIT + 50, t);
        reply(50, GOOD_A, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (acc_cnt < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_reached_byte3", 64'(acc_cnt), 64'd3);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("t5_tx_valid", 64'(o_tx_valid), 64'd0);
        check_val("t5_tx_data", 64'(o_tx_data), 64'd0);
        check_val("t5_sample", 64'(o_sample), 64'd0);
        check_val("t5_dht_start", 64'(o_dht_start), 64'd0);
        stall_len = 0;
        exp_bytes.delete();
        exp_samp.delete();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        wait_start(P_INIT + 50, t);
        check_val("t5_restart", 64'(t), 64'(P_INIT));
        check_val("t5_no_bytes_after", 64'(acc_cnt), 64'd0);

        repeat (5) @(negedge clk);
        check_val("end_bytes_empty", 64'(exp_bytes.size()), 64'd0);
        check_val("end_samples_empty", 64'(exp_samp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
